interrupt_controller: RTL

Priority interrupt/trap controller that arbitrates four external interrupt lines and one software trap request, and hands the winner to the CPU core over a request/acknowledge handshake. It drives the I/TRP status flag update (`I_TRP`/`I_TRP_en`) of the control/status register, and supplies the service vector to the fetch unit. It also owns the per-line mask. Nesting is not supported: one service at a time, ended by RETI.

---
 rtl/interrupt_controller.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/interrupt_controller.sv
// Priority interrupt/trap controller: edge-latched lines plus a software trap,
// arbitrated and handed to the core with a req/ack handshake, ended by RETI.
module interrupt_controller #(
  parameter logic [7:0] VEC_BASE = 8'hF0
) (
  input  logic       clk,
  input  logic       reset_,
  input  logic [3:0] irq_req,
  input  logic       trap_req,
  input  logic       mask_we,
  input  logic [3:0] mask_wdata,
  input  logic       int_ack,
  input  logic       reti,
  output logic       int_req,
  output logic [7:0] int_vec,
  output logic       I_TRP,
  output logic       I_TRP_en,
  output logic [3:0] pending,
  output logic [3:0] irq_mask,
  output logic       in_service
);

  typedef enum logic [1:0] {StIdle, StReq, StService} state_e;

  state_e     state_q, state_d;
  logic [3:0] prev_q, prev_d;
  logic [3:0] pend_q, pend_d;
  logic [3:0] mask_q, mask_d;
  logic       trap_q, trap_d;
  logic       req_q, req_d;
  logic [7:0] vec_q, vec_d;
  logic       itrp_q, itrp_d;
  logic       itrp_en_q, itrp_en_d;
  logic       svc_q, svc_d;
  logic       win_trap_q, win_trap_d;
  logic [1:0] win_line_q, win_line_d;

  logic [3:0] edges, eligible, clr_line;
  logic       clr_trap, found, sel_trap;
  logic [1:0] sel_line;

  assign edges    = irq_req & ~prev_q;
  assign eligible = pend_q & ~mask_q;

  // Trap beats every line; among lines the lowest index wins.
  always_comb begin
    found    = trap_q;
    sel_trap = trap_q;
    sel_line = 2'd0;
    if (!trap_q) begin
      for (int i = 3; i >= 0; i--) begin
        if (eligible[i]) begin
          found    = 1'b1;
          sel_line = 2'(i);
        end
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    req_d      = req_q;
    vec_d      = vec_q;
    itrp_d     = itrp_q;
    itrp_en_d  = 1'b0;
    svc_d      = svc_q;
    win_trap_d = win_trap_q;
    win_line_d = win_line_q;
    clr_line   = 4'b0000;
    clr_trap   = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (found) begin
          state_d    = StReq;
          req_d      = 1'b1;
          win_trap_d = sel_trap;
          win_line_d = sel_line;
          vec_d      = sel_trap ? VEC_BASE
                                : VEC_BASE + {4'b0000, {1'b0, sel_line} + 3'd1, 1'b0};
        end
      end
      StReq: begin
        if (int_ack) begin
          state_d   = StService;
          req_d     = 1'b0;
          itrp_en_d = 1'b1;
          itrp_d    = 1'b1;
          svc_d     = 1'b1;
          if (win_trap_q) clr_trap = 1'b1;
          else            clr_line = 4'b0001 << win_line_q;
        end
      end
      StService: begin
        if (reti) begin
          state_d   = StIdle;
          itrp_en_d = 1'b1;
          itrp_d    = 1'b0;
          svc_d     = 1'b0;
        end
      end
      default: state_d = StIdle;
    endcase
    // New edges/traps override the clear from an ack in the same cycle.
    pend_d = (pend_q & ~clr_line) | edges;
    trap_d = (trap_q & ~clr_trap) | trap_req;
    mask_d = mask_we ? mask_wdata : mask_q;
    prev_d = irq_req;
  end

  always_ff @(posedge clk) begin
    if (!reset_) begin
      state_q    <= StIdle;
      prev_q     <= 4'b0000;
      pend_q     <= 4'b0000;
      mask_q     <= 4'b0000;
      trap_q     <= 1'b0;
      req_q      <= 1'b0;
      vec_q      <= 8'h00;
      itrp_q     <= 1'b0;
      itrp_en_q  <= 1'b0;
      svc_q      <= 1'b0;
      win_trap_q <= 1'b0;
      win_line_q <= 2'd0;
    end else begin
      state_q    <= state_d;
      prev_q     <= prev_d;
      pend_q     <= pend_d;
      mask_q     <= mask_d;
      trap_q     <= trap_d;
      req_q      <= req_d;
      vec_q      <= vec_d;
      itrp_q     <= itrp_d;
      itrp_en_q  <= itrp_en_d;
      svc_q      <= svc_d;
      win_trap_q <= win_trap_d;
      win_line_q <= win_line_d;
    end
  end

  assign int_req    = req_q;
  assign int_vec    = vec_q;
  assign I_TRP      = itrp_q;
  assign I_TRP_en   = itrp_en_q;
  assign pending    = pend_q;
  assign irq_mask   = mask_q;
  assign in_service = svc_q;

endmodule
